nios_setup_mem_test_master: RTL and testbench

- Avalon-MM master that drives the second (s2) port of the dual-port on-chip memory directly, with that port's clken tied high.
- Run sequence: fill a word range with a deterministic pattern, then read it back and compare.
- Gives the Nios subsystem a hardware self-test and scrub engine for on-chip RAM, independent of the CPU port (s1).
- Master-side counterpart of the memory's fixed-latency slave port.

---
 rtl/nios_setup_mem_test_pkg.sv | 23 ++
 rtl/nios_setup_mem_test_master_if.sv | 31 +++
 rtl/nios_setup_mem_test_rd_pipe.sv | 38 +++
 rtl/nios_setup_mem_test_master.sv | 173 +++++++++++++++++
 tb/tb_nios_setup_mem_test_master.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/nios_setup_mem_test_pkg.sv
// Shared types and helpers for the on-chip RAM self-test master.
// Pattern generator is shared by the write and compare paths.
package nios_setup_mem_test_pkg;

    localparam int ADDR_W_D = 12;
    localparam int DATA_W_D = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [DATA_W_D-1:0] pattern(
        input logic [DATA_W_D-1:0] seed,
        input logic [ADDR_W_D-1:0] addr
    );
        return seed ^ DATA_W_D'(addr);
    endfunction

endpackage

// File: rtl/nios_setup_mem_test_master_if.sv
// Avalon-MM bundle for the memory's second (s2) port.
// The master drives the strobe side, the slave returns readdata.
interface nios_setup_mem_test_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/nios_setup_mem_test_rd_pipe.sv
// Tracks outstanding reads so each readdata beat is matched
// to the address that produced it.
module nios_setup_mem_test_rd_pipe #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_pending
);
    localparam logic [LAT-1:0] W_TOP = LAT'(1) << (LAT - 1);

    logic [LAT-1:0]    r_vld;
    logic [ADDR_W-1:0] r_addr [LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) r_addr[i] <= '0;
        end else begin
            if (i_flush) r_vld <= '0;
            else         r_vld <= (r_vld << 1) | LAT'(i_push);
            for (int i = LAT - 1; i > 0; i--) r_addr[i] <= r_addr[i-1];
            r_addr[0] <= i_addr;
        end
    end

    assign o_vld  = r_vld[LAT-1];
    assign o_addr = r_addr[LAT-1];
    // Entries still in flight behind the one being compared now.
    assign o_pending = |(r_vld & ~W_TOP);

endmodule

// File: rtl/nios_setup_mem_test_master.sv
// Fill-then-verify engine for on-chip RAM through its s2 port.
// Writes seed^addr over a wrapped range, reads back and counts mismatches.
module nios_setup_mem_test_master
    import nios_setup_mem_test_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_D,
    parameter int DATA_W       = DATA_W_D,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              check_only,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] seed,
    nios_setup_mem_test_master_if.master avm,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ERR_MAX = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_address;
    logic              r_cs;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_seed;
    logic [ADDR_W-1:0] r_cnt_m1;
    logic [ADDR_W-1:0] r_remain;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_first_err;

    logic              w_cnt_zero;
    logic [ADDR_W-1:0] w_cnt_m1;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_push;
    logic              w_cmp_vld;
    logic [ADDR_W-1:0] w_cmp_addr;
    logic              w_pending;
    logic              w_hit;

    assign w_cnt_zero  = (word_count == '0);
    assign w_cnt_m1    = (word_count >= CNT_MAX) ? '1
                       : ADDR_W'(word_count - 1'b1);
    assign w_next_addr = r_address + ADDR_W'(1);
    assign w_push      = (r_state == S_READ) && !abort;

    nios_setup_mem_test_rd_pipe #(
        .ADDR_W (ADDR_W),
        .LAT    (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_addr    (r_address),
        .i_flush   (abort),
        .o_vld     (w_cmp_vld),
        .o_addr    (w_cmp_addr),
        .o_pending (w_pending)
    );

    assign w_hit = w_cmp_vld
                && (avm.avm_readdata != pattern(r_seed, w_cmp_addr));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_address   <= '0;
            r_cs        <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_base      <= '0;
            r_seed      <= '0;
            r_cnt_m1    <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_hit) begin
                if (r_err_count != ERR_MAX) r_err_count <= r_err_count + 1'b1;
                if (r_err_count == '0)      r_first_err <= w_cmp_addr;
            end
            if (abort) begin
                if (r_state != S_IDLE) r_pass <= 1'b0;
                r_state <= S_IDLE;
                r_cs    <= 1'b0;
                r_write <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: if (start) begin
                        r_base      <= base_addr;
                        r_seed      <= seed;
                        r_cnt_m1    <= w_cnt_m1;
                        r_remain    <= w_cnt_m1;
                        r_address   <= base_addr;
                        r_wdata     <= pattern(seed, base_addr);
                        r_err_count <= '0;
                        r_first_err <= '0;
                        r_pass      <= 1'b0;
                        if (w_cnt_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_cs    <= 1'b1;
                            r_write <= !check_only;
                            r_state <= check_only ? S_READ : S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (r_remain == '0) begin
                            r_state   <= S_READ;
                            r_write   <= 1'b0;
                            r_address <= r_base;
                            r_remain  <= r_cnt_m1;
                        end else begin
                            r_address <= w_next_addr;
                            r_wdata   <= pattern(r_seed, w_next_addr);
                            r_remain  <= r_remain - 1'b1;
                        end
                    end
                    S_READ: begin
                        if (r_remain == '0) begin
                            r_state <= S_DRAIN;
                            r_cs    <= 1'b0;
                        end else begin
                            r_address <= w_next_addr;
                            r_remain  <= r_remain - 1'b1;
                        end
                    end
                    S_DRAIN: if (!w_pending) begin
                        // Last compare lands on this same edge.
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_count == '0) && !w_hit;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign avm.avm_address    = r_address;
    assign avm.avm_chipselect = r_cs;
    assign avm.avm_write      = r_write;
    assign avm.avm_byteenable = {(DATA_W/8){r_cs}};
    assign avm.avm_writedata  = r_wdata;

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_nios_setup_mem_test_master.sv
// Directed bench for the RAM self-test master with a latency-1 memory model.
module tb_nios_setup_mem_test_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, check_only;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [12:0] err_count;
    logic [11:0] first_err_addr;

    always #5 clk = ~clk;

    nios_setup_mem_test_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    nios_setup_mem_test_master #(
        .ADDR_W(12), .DATA_W(32), .READ_LATENCY(1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .check_only     (check_only),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .avm            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    logic [31:0] mem [4096];
    logic        clr_mem, clr_stats, cor_en;
    logic [11:0] cor_addr;
    int          wr_cnt, rd_cnt;

    always @(posedge clk) begin
        if (clr_mem)
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        else if (bus.avm_chipselect && bus.avm_write)
            mem[bus.avm_address] <= bus.avm_writedata;
        bus.avm_readdata <= mem[bus.avm_address]
            ^ ((cor_en && bus.avm_address == cor_addr) ? 32'h1 : 32'h0);
        if (clr_stats) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end else if (bus.avm_chipselect) begin
            if (bus.avm_write) wr_cnt <= wr_cnt + 1;
            else               rd_cnt <= rd_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] base;
        logic [12:0] cnt;
        logic [31:0] seed;
        logic        chk_only;
        logic        pre_zero;
        logic        cor;
        logic [11:0] cor_a;
        int          restart;
        int          exp_err;
        logic [11:0] exp_first;
        logic        exp_pass;
        int          exp_wr;
        int          exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vt [7];

    task automatic run(input vec_t v, input string tag);
        int lat;
        int eff;
        logic [11:0] last;
        cor_en    = v.cor;
        cor_addr  = v.cor_a;
        clr_stats = 1'b1;
        clr_mem   = v.pre_zero;
        @(negedge clk);
        clr_stats  = 1'b0;
        clr_mem    = 1'b0;
        start      = 1'b1;
        base_addr  = v.base;
        word_count = v.cnt;
        seed       = v.seed;
        check_only = v.chk_only;
        lat = -1;
        for (int n = 1; n <= v.exp_lat + 50; n++) begin
            @(negedge clk);
            start = (v.restart != 0) && (n == v.restart);
            if (start) base_addr = 12'h500;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " pass"}, {31'd0, pass}, {31'd0, v.exp_pass});
        chk({tag, " err_count"}, {19'd0, err_count}, v.exp_err);
        chk({tag, " first_err"}, {20'd0, first_err_addr}, {20'd0, v.exp_first});
        chk({tag, " busy_at_done"}, {31'd0, busy}, 0);
        @(negedge clk);
        chk({tag, " done_width"}, {31'd0, done}, 0);
        chk({tag, " writes"}, wr_cnt, v.exp_wr);
        chk({tag, " reads"}, rd_cnt, v.exp_rd);
        eff = (v.cnt > 13'd4096) ? 4096 : int'(v.cnt);
        if (v.exp_wr != 0) begin
            last = v.base + 12'(eff - 1);
            chk({tag, " mem_first"}, mem[v.base], v.seed ^ {20'd0, v.base});
            chk({tag, " mem_last"}, mem[last], v.seed ^ {20'd0, last});
        end
        cor_en = 1'b0;
    endtask

    initial begin
        bit seen_done, seen_cs;
        vt[0] = '{12'h010, 13'd4,    32'h0,         0, 0, 0, 12'h0,   0, 0, 12'h000, 1, 4,    4,    10};
        vt[1] = '{12'hFFE, 13'd4,    32'hA5A5_0000, 0, 0, 0, 12'h0,   0, 0, 12'h000, 1, 4,    4,    10};
        vt[2] = '{12'h010, 13'd8,    32'h0,         0, 0, 1, 12'h012, 0, 1, 12'h012, 0, 8,    8,    18};
        vt[3] = '{12'h020, 13'd0,    32'h0,         0, 0, 0, 12'h0,   0, 0, 12'h000, 1, 0,    0,    1};
        vt[4] = '{12'h000, 13'd3,    32'h0,         1, 1, 0, 12'h0,   0, 2, 12'h001, 0, 0,    3,    5};
        vt[5] = '{12'h100, 13'd5000, 32'h1234_5678, 0, 0, 0, 12'h0,   0, 0, 12'h000, 1, 4096, 4096, 8194};
        vt[6] = '{12'h010, 13'd4,    32'h0,         0, 1, 0, 12'h0,   3, 0, 12'h000, 1, 4,    4,    10};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; check_only = 1'b0;
        base_addr = '0; word_count = '0; seed = '0;
        clr_mem = 1'b1; clr_stats = 1'b1; cor_en = 1'b0; cor_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst chipselect", {31'd0, bus.avm_chipselect}, 0);
        chk("rst write", {31'd0, bus.avm_write}, 0);
        chk("rst byteenable", {28'd0, bus.avm_byteenable}, 0);
        chk("rst address", {20'd0, bus.avm_address}, 0);
        chk("rst busy_done_pass", {29'd0, busy, done, pass}, 0);
        chk("rst err_count", {19'd0, err_count}, 0);
        chk("rst first_err", {20'd0, first_err_addr}, 0);
        reset_n = 1'b1; clr_mem = 1'b0; clr_stats = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run(vt[i], $sformatf("v%0d", i));
        chk("restart ignored mem500", mem[12'h500], 0);

        // Abort on the second read cycle of a 16-word run.
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        start = 1'b1; base_addr = 12'h000; word_count = 13'd16;
        seed = 32'h0; check_only = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort pre cs_rd", {30'd0, bus.avm_chipselect, bus.avm_write}, 32'h2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort cs", {31'd0, bus.avm_chipselect}, 0);
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort done", {31'd0, done}, 0);
        seen_done = 1'b0; seen_cs = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_done |= done;
            seen_cs   |= bus.avm_chipselect;
        end
        chk("abort no_done", {31'd0, seen_done}, 0);
        chk("abort no_cs", {31'd0, seen_cs}, 0);
        chk("abort pass", {31'd0, pass}, 0);
        chk("abort reads", rd_cnt, 2);
        run(vt[0], "post_abort");

        // Abort and start together while idle: no run.
        start = 1'b1; abort = 1'b1; word_count = 13'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort busy", {31'd0, busy}, 0);
        seen_done = 1'b0; seen_cs = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_done |= done;
            seen_cs   |= bus.avm_chipselect;
        end
        chk("idle_abort no_done", {31'd0, seen_done}, 0);
        chk("idle_abort no_cs", {31'd0, seen_cs}, 0);

        // Asynchronous reset mid-run after a failing run.
        run(vt[2], "pre_reset");
        start = 1'b1; base_addr = 12'h040; word_count = 13'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun cs", {31'd0, bus.avm_chipselect}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async cs", {31'd0, bus.avm_chipselect}, 0);
        chk("async busy", {31'd0, busy}, 0);
        chk("async address", {20'd0, bus.avm_address}, 0);
        chk("async writedata", bus.avm_writedata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
